// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the fetch queue: FSM state encoding and PC increment.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_queue_instr_fifo.sv
// Circular instruction buffer with synchronous clear and combinational head read.
module instr_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one memory request at a time and buffers
// returned words with their PC+4 until decode consumes them.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               branch,
  input  logic               jump_reg,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic [ADDR_W-1:0]  jump_reg_addr,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               enable,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_plus_4
);

  localparam int ENTRY_W = INSTR_W + ADDR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  fetch_state_t        state;
  fetch_state_t        state_next;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   req_pc;
  logic [ADDR_W-1:0]   target;
  logic                redirect;
  logic                issue;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  head;

  assign redirect = branch | jump_reg | jump;

  always_comb begin
    target = jump_addr;
    if (branch) begin
      target = branch_addr;
    end else if (jump_reg) begin
      target = jump_reg_addr;
    end
  end

  // The free slot is checked at issue time, so the later push always has room.
  assign issue = (state == ST_READY) && (count < CNT_W'(DEPTH)) && !redirect && !reset;
  assign push  = (state == ST_WAIT) && imem_rvalid && !redirect;
  assign pop   = enable && instr_valid;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (push),
    .push_data ({imem_rdata, req_pc + ADDR_W'(PC_STEP)}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_READY: begin
        if (issue) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          state_next = imem_rvalid ? ST_READY : ST_DROP;
        end else if (imem_rvalid) begin
          state_next = ST_READY;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) state_next = ST_READY;
      end
      default: state_next = ST_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_READY;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state <= state_next;
      if (redirect) begin
        fetch_pc <= target;
      end else if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        req_pc   <= fetch_pc;
      end
    end
  end

  assign instr_valid = !reset && (count != '0);
  assign instr       = instr_valid ? head[ENTRY_W-1:ADDR_W] : '0;
  assign pc_plus_4   = instr_valid ? head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue with a transaction-level reference model
// and directed scenarios pinned by literal expectations.
module tb_fetch_queue;

  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch = 1'b0;
  logic        jump_reg = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] branch_addr = '0;
  logic [31:0] jump_reg_addr = '0;
  logic [31:0] jump_addr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        enable = 1'b1;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_plus_4;

  fetch_queue #(
    .ADDR_W   (ADDR_W),
    .INSTR_W  (INSTR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .branch        (branch),
    .jump_reg      (jump_reg),
    .jump          (jump),
    .branch_addr   (branch_addr),
    .jump_reg_addr (jump_reg_addr),
    .jump_addr     (jump_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .enable        (enable),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .pc_plus_4     (pc_plus_4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // stimulus for the next cycle
  logic        s_reset = 1'b1, s_branch = 1'b0, s_jump_reg = 1'b0, s_jump = 1'b0, s_enable = 1'b1;
  logic [31:0] s_baddr = '0, s_jraddr = '0, s_jaddr = '0;

  // memory responder
  bit          mem_pending = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  int          mem_lat_lo = 1, mem_lat_hi = 1;
  bit          spurious_en = 0;

  // reference model
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_req_pc = '0;
  bit          m_out = 0;
  bit          m_keep = 0;
  logic [31:0] m_instr[$];
  logic [31:0] m_pc4[$];

  bit          rec_on = 0;
  logic [31:0] pops[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus();
    reset         = s_reset;
    branch        = s_branch;
    jump_reg      = s_jump_reg;
    jump          = s_jump;
    branch_addr   = s_baddr;
    jump_reg_addr = s_jraddr;
    jump_addr     = s_jaddr;
    enable        = s_enable;
  endtask

  // Compares every DUT output with what the model says it must be this cycle.
  task automatic check_output();
    logic redir, exp_req, exp_valid;
    redir     = s_branch | s_jump_reg | s_jump;
    exp_req   = !s_reset && !m_out && (m_instr.size() < DEPTH) && !redir;
    exp_valid = !s_reset && (m_instr.size() > 0);
    check_eq("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
    check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    check_eq("instr", instr, exp_valid ? m_instr[0] : 32'h0);
    check_eq("pc_plus_4", pc_plus_4, exp_valid ? m_pc4[0] : 32'h0);
  endtask

  task automatic model_update();
    logic        redir;
    logic [31:0] tgt;
    bit          do_issue, do_pop, do_push;
    redir = s_branch | s_jump_reg | s_jump;
    tgt   = s_branch ? s_baddr : (s_jump_reg ? s_jraddr : s_jaddr);
    if (s_reset) begin
      m_fetch_pc = RESET_PC;
      m_out = 0;
      m_keep = 0;
      m_instr.delete();
      m_pc4.delete();
      return;
    end
    do_issue = !m_out && (m_instr.size() < DEPTH) && !redir;
    if (redir) begin
      m_instr.delete();
      m_pc4.delete();
      m_fetch_pc = tgt;
      if (m_out) begin
        if (imem_rvalid) m_out = 0;
        else m_keep = 0;
      end
    end else begin
      do_pop  = s_enable && (m_instr.size() > 0);
      do_push = m_out && m_keep && imem_rvalid;
      if (do_pop) begin
        void'(m_instr.pop_front());
        void'(m_pc4.pop_front());
      end
      if (do_push) begin
        m_instr.push_back(imem_rdata);
        m_pc4.push_back(m_req_pc + 32'd4);
      end
      if (m_out && imem_rvalid) m_out = 0;
      if (do_issue) begin
        m_req_pc   = m_fetch_pc;
        m_fetch_pc = m_fetch_pc + 32'd4;
        m_out      = 1;
        m_keep     = 1;
      end
    end
  endtask

  task automatic do_cycle();
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (mem_pending) begin
      // a response caught by reset is delivered in the first cycle after it
      if (s_reset) mem_cnt = 0;
      else if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(mem_addr);
        mem_pending = 0;
      end else mem_cnt--;
    end else if (spurious_en && !m_out && !s_reset && ($urandom_range(7, 0) == 0)) begin
      imem_rvalid = 1'b1;
    end
    apply_stimulus();
    #3;
    check_output();
    if (rec_on && instr_valid && s_enable) pops.push_back(pc_plus_4);
    if (imem_req && !mem_pending) begin
      mem_pending = 1;
      mem_addr    = imem_addr;
      mem_cnt     = $urandom_range(mem_lat_hi, mem_lat_lo) - 1;
    end
    model_update();
  endtask

  // Captures the first two issued addresses and the first valid head.
  task automatic observe(input int max, output logic [31:0] a0, output logic [31:0] a1,
                         output logic [31:0] p0, output logic [31:0] i0);
    int na;
    bit gotp;
    na = 0;
    gotp = 0;
    a0 = 'x; a1 = 'x; p0 = 'x; i0 = 'x;
    for (int c = 0; c < max && !(na >= 2 && gotp); c++) begin
      do_cycle();
      if (imem_req) begin
        if (na == 0) a0 = imem_addr;
        else if (na == 1) a1 = imem_addr;
        na++;
      end
      if (instr_valid && !gotp) begin
        p0 = pc_plus_4;
        i0 = instr;
        gotp = 1;
      end
    end
    if (!(na >= 2 && gotp)) begin
      checks++;
      errors++;
      $display("[TB] FAIL observe_timeout: got %0d issues valid=%0d expected 2 issues valid=1", na, gotp);
    end
  endtask

  task automatic wait_issue(input int max);
    bit got;
    got = 0;
    for (int c = 0; c < max && !got; c++) begin
      do_cycle();
      if (imem_req) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL issue_timeout: got no request expected one within %0d cycles", max);
    end
  endtask

  initial begin
    logic [31:0] iss[$];
    logic [31:0] a0, a1, p0, i0;
    int          first_valid;

    // reset state
    s_reset = 1;
    do_cycle();
    do_cycle();
    check_eq("reset_req", {31'b0, imem_req}, 32'h0);
    check_eq("reset_valid", {31'b0, instr_valid}, 32'h0);
    check_eq("reset_instr", instr, 32'h0);
    check_eq("reset_pc4", pc_plus_4, 32'h0);

    // straight-line fetch with 1-cycle memory
    s_reset = 0;
    rec_on = 1;
    first_valid = -1;
    for (int i = 0; i < 10; i++) begin
      do_cycle();
      if (imem_req) iss.push_back(imem_addr);
      if (instr_valid && first_valid < 0) first_valid = i;
    end
    check_eq("seq_addr0", iss[0], 32'h100);
    check_eq("seq_addr1", iss[1], 32'h104);
    check_eq("seq_addr2", iss[2], 32'h108);
    check_eq("first_valid_cycle", first_valid, 32'd2);
    check_eq("seq_pc4_0", pops[0], 32'h104);
    check_eq("seq_pc4_1", pops[1], 32'h108);
    check_eq("seq_pc4_2", pops[2], 32'h10C);

    // stall decode until the queue is full
    s_enable = 0;
    for (int i = 0; i < 15; i++) do_cycle();
    check_eq("fill_depth", m_instr.size(), DEPTH);
    for (int i = 0; i < 5; i++) begin
      do_cycle();
      check_eq("full_no_req", {31'b0, imem_req}, 32'h0);
      check_eq("full_valid", {31'b0, instr_valid}, 32'h1);
    end
    s_enable = 1;
    for (int i = 0; i < 20; i++) do_cycle();
    rec_on = 0;
    check_eq("seq_count_ok", {31'b0, pops.size() >= 10}, 32'h1);
    for (int i = 1; i < pops.size(); i++) check_eq("seq_step", pops[i] - pops[i-1], 32'd4);

    // branch while waiting, response 3 cycles after the request
    mem_lat_lo = 3;
    mem_lat_hi = 3;
    wait_issue(10);
    s_branch = 1;
    s_baddr  = 32'h400;
    do_cycle();
    s_branch = 0;
    observe(20, a0, a1, p0, i0);
    check_eq("branch_addr", a0, 32'h400);
    check_eq("branch_pc4", p0, 32'h404);
    check_eq("branch_instr", i0, mem_word(32'h400));

    // redirect priority
    mem_lat_lo = 1;
    mem_lat_hi = 2;
    s_branch = 1; s_jump_reg = 1; s_jump = 1;
    s_baddr = 32'h400; s_jraddr = 32'h800; s_jaddr = 32'hC00;
    do_cycle();
    s_branch = 0; s_jump_reg = 0; s_jump = 0;
    observe(20, a0, a1, p0, i0);
    check_eq("prio_all", a0, 32'h400);
    s_jump_reg = 1; s_jump = 1;
    do_cycle();
    s_jump_reg = 0; s_jump = 0;
    observe(20, a0, a1, p0, i0);
    check_eq("prio_jr", a0, 32'h800);
    check_eq("prio_jr_pc4", p0, 32'h804);

    // address wrap at the top of the space
    s_jump  = 1;
    s_jaddr = 32'hFFFF_FFFC;
    do_cycle();
    s_jump = 0;
    observe(20, a0, a1, p0, i0);
    check_eq("wrap_addr0", a0, 32'hFFFF_FFFC);
    check_eq("wrap_addr1", a1, 32'h0);
    check_eq("wrap_pc4", p0, 32'h0);

    // reset while a request is outstanding
    mem_lat_lo = 3;
    mem_lat_hi = 3;
    wait_issue(10);
    s_reset = 1;
    do_cycle();
    s_reset = 0;
    mem_lat_lo = 1;
    mem_lat_hi = 1;
    observe(20, a0, a1, p0, i0);
    check_eq("rst_wait_addr", a0, RESET_PC);
    check_eq("rst_wait_pc4", p0, 32'h104);
    check_eq("rst_wait_instr", i0, mem_word(RESET_PC));

    // randomized traffic
    mem_lat_lo = 1;
    mem_lat_hi = 4;
    spurious_en = 1;
    for (int i = 0; i < 4000; i++) begin
      s_reset    = ($urandom_range(199, 0) == 0);
      s_branch   = ($urandom_range(19, 0) == 0);
      s_jump_reg = ($urandom_range(24, 0) == 0);
      s_jump     = ($urandom_range(24, 0) == 0);
      s_enable   = ($urandom_range(9, 0) < 7);
      s_baddr    = $urandom & 32'hFFFF_FFFC;
      s_jraddr   = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
      s_jaddr    = $urandom & 32'h0000_FFFC;
      do_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
